universal_shift_register: RTL
=============================

Name: universal_shift_register

Overview:
Parametrised successor to the team's 8-bit serial-in shift register, generalised to WIDTH bits. Adds left/right shifting, rotate mode, synchronous parallel load, synchronous clear, serial output and a shift counter that pulses word_valid once per WIDTH shifts. It is the common serialiser/deserialiser stage for the feedback-test datapaths.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
RESET_VALUE, 0, WIDTH-bit value loaded into the register by reset and by clear.
CNT_W, derived localparam = max(1, clog2(WIDTH)), width of shift_count. Not user-settable.

Ports:
clk  input  1  rising-edge clock; all state updates on this edge.
reset  input  1  synchronous, active-high reset.
clear  input  1  synchronous clear of register, counter and word_valid.
load  input  1  parallel load strobe.
load_data  input  WIDTH  parallel load value.
shift_enable  input  1  perform one shift or rotate this cycle.
dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
rotate  input  1  1 = recirculate the outgoing bit; 0 = insert serial_in.
serial_in  input  1  bit inserted on shift when rotate=0.
serial_out  output  1  bit at the outgoing end: stored_data[WIDTH-1] if dir=0, stored_data[0] if dir=1; combinational from register and dir.
stored_data  output  WIDTH  current register contents.
shift_count  output  CNT_W  shifts completed in the current word, 0..WIDTH-1.
word_valid  output  1  one-cycle pulse: WIDTH shifts have completed since the last reset, clear, load or word boundary.

Behaviour:
- Reset: synchronous, active-high. When reset=1 at a clk edge: stored_data=RESET_VALUE, shift_count=0, word_valid=0. All other inputs are ignored that cycle.
- Priority per edge: reset > clear > load > shift_enable > hold.
- clear=1: same effect as reset.
- load=1: stored_data=load_data, shift_count=0, word_valid=0. A simultaneous shift_enable is ignored.
- shift_enable=1 with dir=0, rotate=0: reg <= {reg[WIDTH-2:0], serial_in}.
- shift_enable=1 with dir=0, rotate=1: reg <= {reg[WIDTH-2:0], reg[WIDTH-1]}.
- shift_enable=1 with dir=1, rotate=0: reg <= {serial_in, reg[WIDTH-1:1]}.
- shift_enable=1 with dir=1, rotate=1: reg <= {reg[0], reg[WIDTH-1:1]}.
- In rotate mode serial_in is ignored. dir and rotate may change on any cycle; each shift uses the values sampled at that edge.
- Counter: every accepted shift increments shift_count.
  - On the shift that takes shift_count from WIDTH-1 to the wrap, shift_count becomes 0 and word_valid is 1 for the following cycle only.
  - At the same edge, stored_data holds the completed word, so latency from the WIDTH-th shift edge to word_valid and the complete word is 0 extra cycles (both registered at that edge).
- word_valid is 0 on every edge that does not complete a word, including hold cycles; it never stays high for two cycles.
- Back-to-back words (shift_enable held high) produce word_valid every WIDTH cycles.
- Reset, clear or load during a partial word discard the partial count. A word boundary coinciding with load or clear produces no pulse.
- serial_out follows dir combinationally; it is valid before the edge that shifts that bit out.
- No X propagation: every output is defined from the first cycle after reset.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5; assert reset for 1 cycle mid-activity -> stored_data=8'hA5, shift_count=0, word_valid=0 on the next cycle.
- Left deserialise: shift in 1,0,1,1,0,0,1,0 with dir=0, rotate=0 -> stored_data=8'hB2, word_valid high for exactly 1 cycle after the 8th shift, shift_count=0.
- Right shift: load 8'h81, then 3 right shifts with serial_in=0 -> 8'h10. serial_out sequence before each shift is 1,0,0.
- Rotate: load 8'h01; 8 left rotates -> value returns to 8'h01 and word_valid pulses once. serial_in toggling has no effect.
- Priority: load=1 and shift_enable=1 with load_data=8'h3C -> stored_data=8'h3C, shift_count=0. clear=1 with load=1 -> RESET_VALUE.
- Partial-word abort: 5 shifts, then load, then 8 shifts -> word_valid pulses only after the 8th post-load shift. Hold cycles between shifts do not advance the count.

Source files
------------

// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: left/right shift or rotate, parallel load,
// synchronous clear, serial output and a per-word shift counter with word_valid pulse.
module universal_shift_register #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     shift_enable,
  input  logic                     dir,
  input  logic                     rotate,
  input  logic                     serial_in,
  output logic                     serial_out,
  output logic [WIDTH-1:0]         stored_data,
  output logic [((WIDTH > 2) ? $clog2(WIDTH) : 1)-1:0] shift_count,
  output logic                     word_valid
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d, shifted;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             fill_bit;

  // The outgoing bit doubles as the recirculated bit in rotate mode.
  assign serial_out = dir ? data_q[0] : data_q[WIDTH-1];
  assign fill_bit   = rotate ? serial_out : serial_in;

  always_comb begin
    shifted = data_q;
    if (dir) begin
      shifted = {fill_bit, data_q[WIDTH-1:1]};
    end else begin
      shifted = {data_q[WIDTH-2:0], fill_bit};
    end
  end

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    valid_d = 1'b0;
    if (clear) begin
      data_d  = RESET_VALUE;
      count_d = '0;
    end else if (load) begin
      data_d  = load_data;
      count_d = '0;
    end else if (shift_enable) begin
      data_d = shifted;
      if (count_q == LastCount) begin
        count_d = '0;
        valid_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VALUE;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign stored_data = data_q;
  assign shift_count = count_q;
  assign word_valid  = valid_q;

endmodule
